// File: rtl/instr_encoder.sv
// instr_encoder: packs structured instruction requests into 18-bit raw words
// and queues them in a DEPTH-entry FIFO for the decoder side.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (in_ready registered, = !full)
//   in_opcode..in_loop_count  request fields (unused fields are masked)
//   out_valid/out_ready  raw-word handshake (out_valid registered, = !empty)
//   out_instruction      head entry, registered
//   err_illegal          one-cycle pulse after an illegal opcode is accepted
//   issued_count, err_count  saturating statistics
//
// Build option: define ENCODER_STATS_EN to implement the statistics
// counters; otherwise both counter outputs are tied to 0.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic             in_flag,
  input  logic [3:0]       in_apu,
  input  logic [1:0]       in_reg_a,
  input  logic [1:0]       in_reg_b,
  input  logic [1:0]       in_height,
  input  logic [1:0]       in_width,
  input  logic             in_zero,
  input  logic             in_skip,
  input  logic [2:0]       in_loop_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [17:0]      out_instruction,
  output logic             err_illegal,
  output logic [CNT_W-1:0] issued_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned IW    = 18;

  logic [IW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nx;
  logic [PTR_W-1:0] rd_ptr_nx;
  logic [IW-1:0]    enc_word;
  logic [IW-1:0]    head_nx;
  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full_nx;
  logic             empty_nx;

  // Pack the request; fields the opcode does not use stay zero.
  always_comb begin
    enc_word        = '0;
    enc_word[17:13] = in_opcode;
    case (in_opcode)
      5'd4, 5'd7, 5'd8: enc_word[12] = in_flag;
      5'd13: begin
        enc_word[12:11] = in_reg_a;
        enc_word[10:9]  = in_reg_b;
      end
      5'd14: enc_word[12:11] = in_reg_a;
      5'd15: begin
        enc_word[12:9] = in_apu;
        enc_word[8:7]  = in_reg_a;
        enc_word[6:5]  = in_height;
        enc_word[4:3]  = in_width;
        enc_word[2]    = in_zero;
        enc_word[1]    = in_skip;
      end
      5'd16: begin
        enc_word[12:9] = in_apu;
        enc_word[8:7]  = in_reg_a;
        enc_word[6:5]  = in_height;
        enc_word[4:3]  = in_width;
      end
      5'd17, 5'd18: enc_word[12:10] = in_loop_count;
      default: ;
    endcase
  end

  // Handshakes and next-state pointers / flags.
  always_comb begin
    legal     = (in_opcode <= 5'd18);
    accept    = in_valid && in_ready;
    push      = accept && legal;
    pop       = out_valid && out_ready;
    wr_ptr_nx = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_nx = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    empty_nx  = (wr_ptr_nx == rd_ptr_nx);
    full_nx   = (wr_ptr_nx[AW] != rd_ptr_nx[AW]) &&
                (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]);
    // The slot being written this edge becomes the head only when the
    // FIFO will hold exactly that one word, so forward it into the register.
    if (empty_nx) begin
      head_nx = '0;
    end else if (push && (rd_ptr_nx[AW-1:0] == wr_ptr[AW-1:0])) begin
      head_nx = enc_word;
    end else begin
      head_nx = mem[rd_ptr_nx[AW-1:0]];
    end
  end

  // Storage array; no reset needed, pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= enc_word;
    end
  end

  // Pointers and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      in_ready        <= 1'b0;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      err_illegal     <= 1'b0;
    end else begin
      wr_ptr          <= wr_ptr_nx;
      rd_ptr          <= rd_ptr_nx;
      in_ready        <= !full_nx;
      out_valid       <= !empty_nx;
      out_instruction <= head_nx;
      err_illegal     <= accept && !legal;
    end
  end

`ifdef ENCODER_STATS_EN
  // Saturating issue / error counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued_count <= '0;
      err_count    <= '0;
    end else begin
      if (pop && (issued_count != '1)) begin
        issued_count <= issued_count + CNT_W'(1);
      end
      if (accept && !legal && (err_count != '1)) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end
`else
  assign issued_count = '0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based reference model plus
// per-cycle comparison, with directed scenarios pinned by literal words.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam bit STATS =
`ifdef ENCODER_STATS_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct packed {
    logic [4:0] op;
    logic       flag;
    logic [3:0] apu;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] h;
    logic [1:0] w;
    logic       z;
    logic       s;
    logic [2:0] lc;
  } req_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_opcode;
  logic             in_flag;
  logic [3:0]       in_apu;
  logic [1:0]       in_reg_a;
  logic [1:0]       in_reg_b;
  logic [1:0]       in_height;
  logic [1:0]       in_width;
  logic             in_zero;
  logic             in_skip;
  logic [2:0]       in_loop_count;
  logic             out_valid;
  logic             out_ready;
  logic [17:0]      out_instruction;
  logic             err_illegal;
  logic [CNT_W-1:0] issued_count;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [17:0] mq[$];
  logic [17:0] pop_log[$];
  bit          m_en   = 1'b0;
  bit          m_err  = 1'b0;
  int          m_iss  = 0;
  int          m_errc = 0;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_flag(in_flag), .in_apu(in_apu),
    .in_reg_a(in_reg_a), .in_reg_b(in_reg_b), .in_height(in_height),
    .in_width(in_width), .in_zero(in_zero), .in_skip(in_skip),
    .in_loop_count(in_loop_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .err_illegal(err_illegal),
    .issued_count(issued_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input int op, input int flag, input int apu, input int ra,
                              input int rb, input int h, input int w, input int z,
                              input int s, input int lc);
    req_t r;
    r.op = 5'(op); r.flag = 1'(flag); r.apu = 4'(apu); r.ra = 2'(ra); r.rb = 2'(rb);
    r.h = 2'(h); r.w = 2'(w); r.z = 1'(z); r.s = 1'(s); r.lc = 3'(lc);
    return r;
  endfunction

  // Raw word from the format table, built as a sum of shifted fields.
  function automatic logic [17:0] encode(input req_t r);
    int unsigned v;
    int unsigned op;
    op = int'(r.op);
    v  = op * 8192;
    if (op == 4 || op == 7 || op == 8) v += int'(r.flag) * 4096;
    else if (op == 13) v += int'(r.ra) * 2048 + int'(r.rb) * 512;
    else if (op == 14) v += int'(r.ra) * 2048;
    else if (op == 15 || op == 16) begin
      v += int'(r.apu) * 512 + int'(r.ra) * 128 + int'(r.h) * 32 + int'(r.w) * 8;
      if (op == 15) v += int'(r.z) * 4 + int'(r.s) * 2;
    end
    else if (op == 17 || op == 18) v += int'(r.lc) * 1024;
    return 18'(v);
  endfunction

  task automatic drive(input req_t r);
    in_opcode = r.op; in_flag = r.flag; in_apu = r.apu; in_reg_a = r.ra;
    in_reg_b = r.rb; in_height = r.h; in_width = r.w; in_zero = r.z;
    in_skip = r.s; in_loop_count = r.lc;
  endtask

  // Starts and ends at posedge+1; returns once the request has been accepted.
  task automatic send(input req_t r);
    bit rdy;
    drive(r);
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout", 32'(1), 32'(0));
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #2;
    reset_n   = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drain with out_ready high; returns number of pops.
  task automatic drain(output int cnt);
    cnt = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 50 && out_valid; k++) begin
      @(posedge clk); #1;
      cnt++;
    end
    out_ready = 1'b0;
    if (out_valid) check("drain_timeout", 32'(1), 32'(0));
  endtask

  // Reference model: updates on each active edge from the inputs alone.
  initial begin : model
    bit acc;
    bit pop;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        mq.delete();
        m_en = 1'b0; m_err = 1'b0; m_iss = 0; m_errc = 0;
      end else begin
        acc   = in_valid && m_en && (mq.size() < DEPTH);
        pop   = (mq.size() != 0) && out_ready;
        m_err = acc && (in_opcode > 5'd18);
        if (pop) begin
          void'(mq.pop_front());
          if (m_iss < (1 << CNT_W) - 1) m_iss++;
        end
        if (acc && in_opcode <= 5'd18)
          mq.push_back(encode(mk(int'(in_opcode), int'(in_flag), int'(in_apu),
                                 int'(in_reg_a), int'(in_reg_b), int'(in_height),
                                 int'(in_width), int'(in_zero), int'(in_skip),
                                 int'(in_loop_count))));
        if (acc && in_opcode > 5'd18 && m_errc < (1 << CNT_W) - 1) m_errc++;
        m_en = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("in_ready", 32'(in_ready), 32'(m_en && (mq.size() < DEPTH)));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("out_instruction", 32'(out_instruction), 32'(mq[0]));
        check("err_illegal", 32'(err_illegal), 32'(m_err));
        check("issued_count", 32'(issued_count), STATS ? 32'(m_iss) : 32'(0));
        check("err_count", 32'(err_count), STATS ? 32'(m_errc) : 32'(0));
        if (out_valid && out_ready) pop_log.push_back(out_instruction);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int   cnt;
    int   ops[10];
    req_t r;
    ops = '{0, 4, 7, 8, 9, 12, 13, 15, 16, 18};
    reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_instruction", 32'(out_instruction), 32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));
    check("post_rst_out_valid", 32'(out_valid), 32'(0));

    // LOAD encoding
    send(mk(15, 1, 10, 2, 3, 1, 3, 1, 0, 7));
    check("load_word", 32'(out_instruction), 32'(18'b01111_1010_10_01_11_1_0_0));
    check("load_valid", 32'(out_valid), 32'(1));
    drain(cnt);

    // COPY masking
    send(mk(13, 1, 15, 3, 1, 3, 3, 1, 1, 7));
    check("copy_word", 32'(out_instruction), 32'(18'b01101_11_01_000000000));
    drain(cnt);

    // Loop opcode
    send(mk(17, 1, 15, 3, 3, 3, 3, 1, 1, 5));
    check("loop_word", 32'(out_instruction), 32'(18'b10001_101_0000000000));
    drain(cnt);

    // Fill and full
    do_reset();
    pop_log.delete();
    send(mk(4, 1, 3, 1, 2, 0, 0, 0, 0, 0));
    send(mk(4, 0, 5, 0, 0, 0, 0, 1, 0, 0));
    send(mk(4, 1, 0, 0, 0, 2, 1, 0, 0, 0));
    send(mk(4, 0, 0, 3, 0, 0, 0, 0, 1, 6));
    check("full_in_ready", 32'(in_ready), 32'(0));
    fork
      send(mk(4, 0, 15, 3, 3, 3, 3, 1, 1, 7));
      begin
        repeat (3) @(posedge clk);
        #1;
        check("full_held_in_ready", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
      end
    join
    drain(cnt);
    check("fill_pop_count", 32'(pop_log.size()), 32'(5));
    if (pop_log.size() == 5) begin
      check("fill_first", 32'(pop_log[0]), 32'(18'b00100_1_000000000000));
      check("fill_fifth", 32'(pop_log[4]), 32'(18'b00100_0_000000000000));
    end

    // Illegal opcodes back-to-back
    do_reset();
    send(mk(19, 1, 1, 1, 1, 1, 1, 1, 1, 1));
    check("illegal1_pulse", 32'(err_illegal), 32'(1));
    send(mk(31, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("illegal2_pulse", 32'(err_illegal), 32'(1));
    check("illegal_no_output", 32'(out_valid), 32'(0));
    @(posedge clk); #1;
    check("illegal_pulse_end", 32'(err_illegal), 32'(0));
    check("illegal_err_count", 32'(err_count), STATS ? 32'(2) : 32'(0));

    // Steady-state streaming at half occupancy
    do_reset();
    send(mk(17, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    send(mk(18, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    for (int i = 0; i < 10; i++) begin
      r = mk(ops[i], i & 1, i + 3, i, i + 1, i + 2, i + 3, i & 1, (i >> 1) & 1, i);
      drive(r);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check("stream_in_ready", 32'(in_ready), 32'(1));
      check("stream_out_valid", 32'(out_valid), 32'(1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_issued", 32'(issued_count), STATS ? 32'(10) : 32'(0));
    drain(cnt);
    check("stream_occupancy", 32'(cnt), 32'(2));

    // Reset mid-operation
    do_reset();
    send(mk(8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    send(mk(14, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    send(mk(16, 0, 9, 1, 0, 2, 2, 1, 1, 0));
    #3 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(0));
    check("midrst_issued", 32'(issued_count), 32'(0));
    check("midrst_err", 32'(err_count), 32'(0));
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_out_valid", 32'(out_valid), 32'(0));
    check("after_rst_in_ready", 32'(in_ready), 32'(1));
    send(mk(14, 1, 7, 2, 3, 1, 1, 1, 1, 7));
    check("after_rst_word", 32'(out_instruction), 32'(18'b01110_10_00000000000));
    check("after_rst_valid", 32'(out_valid), 32'(1));
    drain(cnt);
    check("after_rst_count", 32'(cnt), 32'(1));

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
